// File: rtl/jbi_rdma_rtn_asm_pkg.sv
// Shared JBI return-path definitions: line geometry, assembler FSM encoding,
// queue entry layout and the beat-slot addressing helper.
package jbi_rdma_rtn_asm_pkg;

  localparam int RTN_BEATS   = 16;
  localparam int RTN_BEAT_W  = 32;
  localparam int RTN_LINE_W  = 512;
  localparam int CTAG_W      = 15;
  localparam int BEAT_IDX_W  = $clog2(RTN_BEATS);
  localparam int LINE_IDX_W  = $clog2(RTN_LINE_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } rtn_state_e;

  typedef struct packed {
    logic                  ue;
    logic [CTAG_W-1:0]     ctag;
    logic [RTN_LINE_W-1:0] data;
  } rtn_entry_t;

  localparam int RTN_ENTRY_W = $bits(rtn_entry_t);

  // Beat 0 lands in the top word, so slot base is (BEATS-1-idx)*32.
  function automatic logic [LINE_IDX_W-1:0] beat_lsb(input logic [BEAT_IDX_W-1:0] idx);
    return {~idx, 5'd0};
  endfunction

endpackage

// File: rtl/jbi_rtn_fifo.sv
// Parameterized synchronous FIFO with registered storage, occupancy count and
// full/empty flags; a pop on a full queue frees the slot for a same-cycle push.
module jbi_rtn_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   cnt_r;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic [PTR_W:0]   cnt_nxt_s;

  // Qualify push/pop against occupancy and compute next count.
  always_comb begin
    do_pop_s  = pop & ~empty_r;
    do_push_s = push & (~full_r | do_pop_s);
    cnt_nxt_s = cnt_r;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Storage, pointers and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      cnt_r   <= cnt_nxt_s;
      full_r  <= (cnt_nxt_s == FULL_CNT);
      empty_r <= (cnt_nxt_s == '0);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign cnt   = cnt_r;

endmodule

// File: rtl/jbi_rdma_rtn_asm.sv
// Assembles scbuf RDMA read returns (ctag header + 16 data beats + lagging UE)
// into 64B line entries and queues them for the JBI return path.
module jbi_rdma_rtn_asm
  import jbi_rdma_rtn_asm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int BEATS = RTN_BEATS
) (
  input  logic                     rclk,
  input  logic                     arst,
  input  logic                     scbuf_jbi_ctag_vld,
  input  logic [31:0]              scbuf_jbi_data,
  input  logic                     scbuf_jbi_ue_err,
  input  logic                     jbi_rtn_pop,
  output logic                     rtn_vld,
  output logic [14:0]              rtn_ctag,
  output logic [511:0]             rtn_data,
  output logic                     rtn_ue,
  output logic [$clog2(DEPTH):0]   rtn_cnt,
  output logic                     rtn_ovf_err,
  output logic                     rtn_proto_err
);

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS-1);
  localparam logic [BEAT_IDX_W-1:0] BEAT_ONE  = BEAT_IDX_W'(1);

  rtn_state_e              state_r, state_nxt_s;
  logic [BEAT_IDX_W-1:0]   beat_cnt_r, beat_cnt_nxt_s;
  logic [CTAG_W-1:0]       ctag_r, ctag_nxt_s;
  logic                    ue_acc_r, ue_acc_nxt_s;
  logic [RTN_LINE_W-1:0]   line_r;
  logic                    beat_we_s;
  logic                    push_s;
  logic                    proto_s;
  logic                    ovf_s;
  logic                    ovf_err_r;
  logic                    proto_err_r;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  rtn_entry_t              entry_s;
  rtn_entry_t              head_s;

  // Next-state, beat-write and push decisions for the line assembler.
  always_comb begin
    state_nxt_s    = state_r;
    beat_cnt_nxt_s = beat_cnt_r;
    ctag_nxt_s     = ctag_r;
    ue_acc_nxt_s   = ue_acc_r;
    beat_we_s      = 1'b0;
    push_s         = 1'b0;
    proto_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (scbuf_jbi_ctag_vld) begin
          ctag_nxt_s     = scbuf_jbi_data[CTAG_W-1:0];
          ue_acc_nxt_s   = 1'b0;
          beat_cnt_nxt_s = '0;
          state_nxt_s    = ST_DATA;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (scbuf_jbi_ctag_vld) begin
          // Header mid-line: drop the partial line and restart on the new ctag.
          proto_s        = 1'b1;
          ctag_nxt_s     = scbuf_jbi_data[CTAG_W-1:0];
          ue_acc_nxt_s   = 1'b0;
          beat_cnt_nxt_s = '0;
          state_nxt_s    = ST_DATA;
        end else begin
          beat_we_s = 1'b1;
          if (beat_cnt_r != '0) begin
            ue_acc_nxt_s = ue_acc_r | scbuf_jbi_ue_err;
          end else begin
            ue_acc_nxt_s = ue_acc_r;
          end
          if (beat_cnt_r == LAST_BEAT) begin
            beat_cnt_nxt_s = '0;
            state_nxt_s    = ST_TAIL;
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + BEAT_ONE;
            state_nxt_s    = ST_DATA;
          end
        end
      end
      ST_TAIL: begin
        push_s = 1'b1;
        if (scbuf_jbi_ctag_vld) begin
          ctag_nxt_s     = scbuf_jbi_data[CTAG_W-1:0];
          ue_acc_nxt_s   = 1'b0;
          beat_cnt_nxt_s = '0;
          state_nxt_s    = ST_DATA;
        end else begin
          ue_acc_nxt_s   = ue_acc_r | scbuf_jbi_ue_err;
          state_nxt_s    = ST_IDLE;
        end
      end
      default: begin
        beat_cnt_nxt_s = '0;
        state_nxt_s    = ST_IDLE;
      end
    endcase
  end

  assign ovf_s   = push_s & fifo_full_s & ~jbi_rtn_pop;
  assign entry_s = '{ue: ue_acc_r | scbuf_jbi_ue_err, ctag: ctag_r, data: line_r};

  // Assembler state, line buffer and one-cycle error pulses.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      state_r     <= ST_IDLE;
      beat_cnt_r  <= '0;
      ctag_r      <= '0;
      ue_acc_r    <= 1'b0;
      line_r      <= '0;
      ovf_err_r   <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      beat_cnt_r  <= beat_cnt_nxt_s;
      ctag_r      <= ctag_nxt_s;
      ue_acc_r    <= ue_acc_nxt_s;
      ovf_err_r   <= ovf_s;
      proto_err_r <= proto_s;
      if (beat_we_s) begin
        line_r[beat_lsb(beat_cnt_r) +: RTN_BEAT_W] <= scbuf_jbi_data;
      end
    end
  end

  jbi_rtn_fifo #(
    .WIDTH (RTN_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (rclk),
    .rst   (arst),
    .push  (push_s),
    .pop   (jbi_rtn_pop),
    .din   (entry_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .cnt   (rtn_cnt)
  );

  assign rtn_vld       = ~fifo_empty_s;
  assign rtn_ctag      = head_s.ctag;
  assign rtn_data      = head_s.data;
  assign rtn_ue        = head_s.ue;
  assign rtn_ovf_err   = ovf_err_r;
  assign rtn_proto_err = proto_err_r;

endmodule

// File: tb/tb_jbi_rdma_rtn_asm.sv
// Directed self-checking bench for jbi_rdma_rtn_asm (DEPTH=2).
module tb_jbi_rdma_rtn_asm;

  logic         rclk = 1'b0;
  logic         arst;
  logic         ctag_vld;
  logic [31:0]  data;
  logic         ue_err;
  logic         pop;
  logic         rtn_vld;
  logic [14:0]  rtn_ctag;
  logic [511:0] rtn_data;
  logic         rtn_ue;
  logic [1:0]   rtn_cnt;
  logic         rtn_ovf_err;
  logic         rtn_proto_err;

  int n_checks = 0;
  int n_pass   = 0;
  int ovf_seen = 0;
  int proto_seen = 0;

  jbi_rdma_rtn_asm #(.DEPTH(2)) dut (
    .rclk               (rclk),
    .arst               (arst),
    .scbuf_jbi_ctag_vld (ctag_vld),
    .scbuf_jbi_data     (data),
    .scbuf_jbi_ue_err   (ue_err),
    .jbi_rtn_pop        (pop),
    .rtn_vld            (rtn_vld),
    .rtn_ctag           (rtn_ctag),
    .rtn_data           (rtn_data),
    .rtn_ue             (rtn_ue),
    .rtn_cnt            (rtn_cnt),
    .rtn_ovf_err        (rtn_ovf_err),
    .rtn_proto_err      (rtn_proto_err)
  );

  always #5 rclk = ~rclk;

  always @(negedge rclk) begin
    if (rtn_ovf_err === 1'b1) ovf_seen++;
    if (rtn_proto_err === 1'b1) proto_seen++;
  end

  function automatic logic [511:0] exp_line(input logic [31:0] base);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) l[(15-i)*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [31:0] d, input logic ue, input logic p);
    ctag_vld = cv; data = d; ue_err = ue; pop = p;
    tick();
    ctag_vld = 1'b0; data = 32'd0; ue_err = 1'b0; pop = 1'b0;
  endtask

  task automatic hdr(input logic [14:0] ctag);
    drive(1'b1, {17'd0, ctag}, 1'b0, 1'b0);
  endtask

  // Beat i is header offset i+1; ue_at selects which offset carries ue_err.
  task automatic beats(input logic [31:0] base, input int ue_at);
    for (int i = 0; i < 16; i++) drive(1'b0, base + 32'(i), (ue_at == i + 1), 1'b0);
  endtask

  task automatic run_line(input logic [14:0] ctag, input logic [31:0] base, input int ue_at);
    hdr(ctag);
    beats(base, ue_at);
    drive(1'b0, 32'd0, (ue_at == 17), 1'b0);
  endtask

  task automatic do_pop();
    drive(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    arst = 1'b1; ctag_vld = 1'b0; data = 32'd0; ue_err = 1'b0; pop = 1'b0;
    tick(); tick();
    n_checks++; if (rtn_vld !== 1'b0) $display("FAIL reset_vld: got %0b want 0", rtn_vld); else n_pass++;
    n_checks++; if (rtn_cnt !== 2'd0) $display("FAIL reset_cnt: got %0d want 0", rtn_cnt); else n_pass++;
    n_checks++; if (rtn_ue !== 1'b0) $display("FAIL reset_ue: got %0b want 0", rtn_ue); else n_pass++;
    n_checks++; if (rtn_ovf_err !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", rtn_ovf_err); else n_pass++;
    n_checks++; if (rtn_proto_err !== 1'b0) $display("FAIL reset_proto: got %0b want 0", rtn_proto_err); else n_pass++;
    n_checks++; if (rtn_ctag !== 15'd0) $display("FAIL reset_ctag: got %0h want 0", rtn_ctag); else n_pass++;
    n_checks++; if (rtn_data !== 512'd0) $display("FAIL reset_data: got %0h want 0", rtn_data); else n_pass++;
    arst = 1'b0;
    tick();
  endtask

  task automatic test_single_line();
    ovf_seen = 0; proto_seen = 0;
    hdr(15'h1A5C);
    beats(32'h0, -1);
    n_checks++; if (rtn_vld !== 1'b0) $display("FAIL single_early_vld: got %0b want 0 at t+17", rtn_vld); else n_pass++;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    n_checks++; if (rtn_vld !== 1'b1) $display("FAIL single_vld: got %0b want 1 at t+18", rtn_vld); else n_pass++;
    n_checks++; if (rtn_ctag !== 15'h1A5C) $display("FAIL single_ctag: got %0h want 1a5c", rtn_ctag); else n_pass++;
    n_checks++; if (rtn_data[511:480] !== 32'h0) $display("FAIL single_beat0: got %0h want 0", rtn_data[511:480]); else n_pass++;
    n_checks++; if (rtn_data[31:0] !== 32'hF) $display("FAIL single_beat15: got %0h want f", rtn_data[31:0]); else n_pass++;
    n_checks++; if (rtn_data !== exp_line(32'h0)) $display("FAIL single_line: got %0h want %0h", rtn_data, exp_line(32'h0)); else n_pass++;
    n_checks++; if (rtn_ue !== 1'b0) $display("FAIL single_ue: got %0b want 0", rtn_ue); else n_pass++;
    n_checks++; if (rtn_cnt !== 2'd1) $display("FAIL single_cnt: got %0d want 1", rtn_cnt); else n_pass++;
    do_pop();
    n_checks++; if (rtn_cnt !== 2'd0 || rtn_vld !== 1'b0) $display("FAIL single_pop: got cnt %0d vld %0b want 0 0", rtn_cnt, rtn_vld); else n_pass++;
    do_pop();
    n_checks++; if (rtn_cnt !== 2'd0) $display("FAIL empty_pop_cnt: got %0d want 0", rtn_cnt); else n_pass++;
  endtask

  task automatic test_ue_align();
    run_line(15'h0011, 32'h1100, 17);
    n_checks++; if (rtn_ue !== 1'b1) $display("FAIL ue_last_beat: got %0b want 1", rtn_ue); else n_pass++;
    do_pop();
    run_line(15'h0012, 32'h1200, 1);
    n_checks++; if (rtn_ue !== 1'b0) $display("FAIL ue_hdr_plus1: got %0b want 0", rtn_ue); else n_pass++;
    do_pop();
    run_line(15'h0013, 32'h1300, 9);
    n_checks++; if (rtn_ue !== 1'b1) $display("FAIL ue_mid_beat: got %0b want 1", rtn_ue); else n_pass++;
    do_pop();
    run_line(15'h0014, 32'h1400, 18);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    n_checks++; if (rtn_ue !== 1'b0 || rtn_ctag !== 15'h0014) $display("FAIL ue_idle: got ue %0b ctag %0h want 0 14", rtn_ue, rtn_ctag); else n_pass++;
    do_pop();
  endtask

  task automatic test_back_to_back();
    ovf_seen = 0; proto_seen = 0;
    hdr(15'h0001);
    beats(32'h100, -1);
    hdr(15'h0002);
    beats(32'h200, -1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    n_checks++; if (rtn_cnt !== 2'd2) $display("FAIL b2b_cnt: got %0d want 2", rtn_cnt); else n_pass++;
    n_checks++; if (rtn_ctag !== 15'h0001) $display("FAIL b2b_head1_ctag: got %0h want 1", rtn_ctag); else n_pass++;
    n_checks++; if (rtn_data !== exp_line(32'h100)) $display("FAIL b2b_head1_data: got %0h want %0h", rtn_data, exp_line(32'h100)); else n_pass++;
    do_pop();
    n_checks++; if (rtn_ctag !== 15'h0002) $display("FAIL b2b_head2_ctag: got %0h want 2", rtn_ctag); else n_pass++;
    n_checks++; if (rtn_data !== exp_line(32'h200)) $display("FAIL b2b_head2_data: got %0h want %0h", rtn_data, exp_line(32'h200)); else n_pass++;
    do_pop();
    n_checks++; if (ovf_seen !== 0 || proto_seen !== 0) $display("FAIL b2b_err: got ovf %0d proto %0d want 0 0", ovf_seen, proto_seen); else n_pass++;
  endtask

  task automatic test_overflow();
    ovf_seen = 0;
    run_line(15'h0031, 32'h3100, -1);
    run_line(15'h0032, 32'h3200, -1);
    run_line(15'h0033, 32'h3300, -1);
    n_checks++; if (rtn_ovf_err !== 1'b1) $display("FAIL ovf_pulse: got %0b want 1", rtn_ovf_err); else n_pass++;
    tick();
    n_checks++; if (rtn_ovf_err !== 1'b0) $display("FAIL ovf_pulse_end: got %0b want 0", rtn_ovf_err); else n_pass++;
    n_checks++; if (ovf_seen !== 1) $display("FAIL ovf_width: got %0d cycles want 1", ovf_seen); else n_pass++;
    n_checks++; if (rtn_cnt !== 2'd2) $display("FAIL ovf_cnt: got %0d want 2", rtn_cnt); else n_pass++;
    n_checks++; if (rtn_ctag !== 15'h0031) $display("FAIL ovf_head: got %0h want 31", rtn_ctag); else n_pass++;
    do_pop();
    do_pop();
    n_checks++; if (rtn_vld !== 1'b0) $display("FAIL ovf_drain: got vld %0b want 0", rtn_vld); else n_pass++;
    ovf_seen = 0;
    run_line(15'h0041, 32'h4100, -1);
    run_line(15'h0042, 32'h4200, -1);
    hdr(15'h0043);
    beats(32'h4300, -1);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    n_checks++; if (rtn_cnt !== 2'd2) $display("FAIL pop_full_cnt: got %0d want 2", rtn_cnt); else n_pass++;
    n_checks++; if (rtn_ctag !== 15'h0042) $display("FAIL pop_full_head: got %0h want 42", rtn_ctag); else n_pass++;
    tick();
    n_checks++; if (ovf_seen !== 0) $display("FAIL pop_full_ovf: got %0d want 0", ovf_seen); else n_pass++;
    do_pop();
    n_checks++; if (rtn_ctag !== 15'h0043 || rtn_data !== exp_line(32'h4300)) $display("FAIL pop_full_line3: got ctag %0h want 43", rtn_ctag); else n_pass++;
    do_pop();
  endtask

  task automatic test_proto();
    proto_seen = 0; ovf_seen = 0;
    hdr(15'h0055);
    for (int i = 0; i < 5; i++) drive(1'b0, 32'h500 + 32'(i), 1'b0, 1'b0);
    hdr(15'h0077);
    n_checks++; if (rtn_proto_err !== 1'b1) $display("FAIL proto_pulse: got %0b want 1", rtn_proto_err); else n_pass++;
    beats(32'h700, -1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    n_checks++; if (proto_seen !== 1) $display("FAIL proto_width: got %0d cycles want 1", proto_seen); else n_pass++;
    n_checks++; if (rtn_cnt !== 2'd1) $display("FAIL proto_cnt: got %0d want 1", rtn_cnt); else n_pass++;
    n_checks++; if (rtn_ctag !== 15'h0077) $display("FAIL proto_ctag: got %0h want 77", rtn_ctag); else n_pass++;
    n_checks++; if (rtn_data !== exp_line(32'h700)) $display("FAIL proto_data: got %0h want %0h", rtn_data, exp_line(32'h700)); else n_pass++;
    do_pop();
  endtask

  task automatic test_reset_mid();
    run_line(15'h0021, 32'h2100, -1);
    hdr(15'h0066);
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h600 + 32'(i), 1'b0, 1'b0);
    arst = 1'b1;
    #2;
    n_checks++; if (rtn_vld !== 1'b0 || rtn_cnt !== 2'd0) $display("FAIL rst_mid_async: got vld %0b cnt %0d want 0 0", rtn_vld, rtn_cnt); else n_pass++;
    tick();
    arst = 1'b0;
    tick();
    ovf_seen = 0; proto_seen = 0;
    run_line(15'h2BCD, 32'hA0, -1);
    n_checks++; if (rtn_cnt !== 2'd1 || rtn_ctag !== 15'h2BCD) $display("FAIL rst_mid_line: got cnt %0d ctag %0h want 1 2bcd", rtn_cnt, rtn_ctag); else n_pass++;
    n_checks++; if (rtn_data !== exp_line(32'hA0)) $display("FAIL rst_mid_data: got %0h want %0h", rtn_data, exp_line(32'hA0)); else n_pass++;
    tick();
    n_checks++; if (ovf_seen !== 0 || proto_seen !== 0) $display("FAIL rst_mid_err: got ovf %0d proto %0d want 0 0", ovf_seen, proto_seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_ue_align();
    test_back_to_back();
    test_overflow();
    test_proto();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jbi_rdma_rtn_asm.md
Name: jbi_rdma_rtn_asm

Overview:
- Receives the RDMA read return stream from the L2 scbuf rdma-read stage: one ctag header beat, then 16 consecutive 32-bit data beats (one 64B line), plus a per-beat uncorrectable-error flag arriving one cycle after its beat.
- Assembles each line into a 512-bit entry with its ctag and a sticky UE flag.
- Queues entries for the JBI PCI/J-bus return path behind a valid/pop handshake.
- Sits in the JBI, directly downstream of scbuf.

Parameters:
- DEPTH, 2, return-queue entries (power of 2, >=2).
- BEATS, 16, 32-bit data beats per line (fixed by the L2 return schedule).

Ports:
- rclk in 1: clock.
- arst in 1: asynchronous active-high reset.
- scbuf_jbi_ctag_vld in 1: header beat; scbuf_jbi_data[14:0] = ctag this cycle.
- scbuf_jbi_data in 32: header ctag or data beat.
- scbuf_jbi_ue_err in 1: UE for the data beat presented in the previous cycle.
- jbi_rtn_pop in 1: consumer takes the head entry; ignored when empty.
- rtn_vld out 1: queue non-empty.
- rtn_ctag out 15: head entry ctag.
- rtn_data out 512: head entry line, beat 0 in [511:480], beat 15 in [31:0].
- rtn_ue out 1: head entry contains at least one UE beat.
- rtn_cnt out log2(DEPTH)+1: occupancy.
- rtn_ovf_err out 1: one-cycle pulse, line dropped because the queue was full.
- rtn_proto_err out 1: one-cycle pulse, header arrived mid-line.

Behaviour:
- Reset (async assert, sync to rclk on release):
  - FSM=IDLE, beat counter=0, queue empty.
  - All outputs 0: rtn_vld, rtn_cnt, rtn_ue, rtn_ovf_err, rtn_proto_err, rtn_ctag, rtn_data.
- FSM states:
  - IDLE: on ctag_vld, latch ctag=data[14:0], clear the assembly UE flag, cnt=0, go to DATA.
  - DATA: every cycle write data into beat slot cnt, cnt++. At cnt=BEATS-1 go to TAIL. There is no data qualifier; beats are the BEATS cycles directly after the header.
  - TAIL: lasts one cycle and captures the UE of the last beat. At the end of the cycle, push {ctag, line, ue} if the queue has space, then return to IDLE. If ctag_vld is asserted in the same TAIL cycle, the new header is accepted and the FSM goes straight to DATA (back-to-back lines, zero bubble).
- UE accumulation:
  - ue_acc |= scbuf_jbi_ue_err in the cycles from header+2 through header+17 inclusive, i.e. the DATA cycles from cnt>=1 plus TAIL.
  - ue_err in the cycle directly after the header is ignored.
  - ue_err in IDLE is ignored.
- Protocol error: ctag_vld while in DATA:
  - the partial line is discarded (not pushed);
  - rtn_proto_err pulses the next cycle;
  - the new header is latched and DATA restarts at cnt=0.
- Push/pop:
  - Push happens at the end of TAIL.
  - Full with no pop in that cycle: entry dropped, rtn_ovf_err pulses the next cycle, queue unchanged.
  - Full with pop in the same cycle: push succeeds and cnt stays DEPTH.
  - Pop when empty: no-op.
- Outputs:
  - Head outputs are registered queue contents and are valid whenever rtn_vld=1.
  - The values of rtn_ctag, rtn_data and rtn_ue when rtn_vld=0 are don't-care, except after reset, where they are 0.
- Latency: header at cycle t; last beat at t+16; entry visible (rtn_vld) at t+18.
- Pointers wrap modulo DEPTH; rtn_cnt never exceeds DEPTH.
- Reset mid-line: the partial line is discarded with no error pulse.

Decomposition:
- Shared JBI package holds:
  - RTN_BEATS=16, RTN_LINE_W=512, CTAG_W=15;
  - the FSM state encoding (IDLE/DATA/TAIL);
  - the entry struct {ue, ctag[14:0], data[511:0]}.
- One natural sub-module: jbi_rtn_fifo. It is a parameterized sync FIFO (width, DEPTH) with push/pop/full/empty/cnt and async active-high reset.
- The FSM, beat register and UE accumulation live in the top module.

Test Plan:
- Single line: header ctag=0x1A5C, beats 0x00000000..0x0000000F, no UE -> at t+18 rtn_vld=1, rtn_ctag=0x1A5C, rtn_data[511:480]=0, rtn_data[31:0]=0xF, rtn_ue=0, rtn_cnt=1.
- UE alignment:
  - ue_err at header+17 (last beat) -> rtn_ue=1.
  - separate line with ue_err only at header+1 -> rtn_ue=0.
  - ue_err only at header+18 (IDLE) -> rtn_ue=0.
- Back-to-back: second header in the TAIL cycle of the first line, ctags 0x0001/0x0002 -> both lines queued in order, rtn_cnt=2, no error pulses.
- Overflow (DEPTH=2): three lines without pop -> third dropped, rtn_ovf_err pulse=1 for exactly one cycle, rtn_cnt=2. Repeat with jbi_rtn_pop asserted in the third line's TAIL cycle -> no drop, cnt stays 2, head advances to line 2.
- Protocol error: header, 5 beats, new header ctag=0x0077, 16 beats -> rtn_proto_err one-cycle pulse, only one entry queued, with ctag=0x0077.
- Reset mid-line: arst asserted at beat 8 -> rtn_vld=0 immediately (async). After release, a fresh line is assembled correctly, with no error pulses.
